// File: rtl/mem_scan_display_pkg.sv
// Shared definitions for the memory viewer: scan-mode encodings, blank pattern
// and the active-low hex-to-segment decoder.
package mem_scan_display_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mem_scan_display_ram.sv
// Simple dual-port RAM, synchronous 1-cycle read. A same-address write and read
// in one cycle returns the old word.
module mem_scan_display_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_scan_display.sv
// Memory viewer: scans RAM addresses (hold/auto/manual) and multiplexes the word
// and its address onto an N-digit active-low seven-segment display.
module mem_scan_display
    import mem_scan_display_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 16,
    parameter int STEP_BITS    = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [1:0]            mode,
    input  logic                  step,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            sseg
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SH_W  = IDX_W + 3;
    localparam int PAD_W = (4 * NUM_DIGITS > ADDR_W) ? 4 * NUM_DIGITS : ADDR_W;
    localparam logic [SH_W-1:0] DATA_SH = SH_W'(DATA_W);

    logic [DATA_W-1:0]       rd_data;
    logic [DATA_W-1:0]       data_q;
    logic [1:0]              mode_q;
    logic                    step_q;
    logic [STEP_BITS-1:0]    step_cnt;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [PAD_W-1:0]        addr_pad;
    logic [SH_W-1:0]         digit_sh;
    logic [3:0]              nibble;
    logic                    dp_n;

    mem_scan_display_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (cur_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= rd_data;
        end
    end

    // A mode change only clears the auto counter; steps landing in that cycle are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr <= '0;
            mode_q   <= MODE_HOLD;
            step_q   <= 1'b0;
            step_cnt <= '0;
        end else begin
            mode_q <= mode;
            step_q <= step;
            if (mode != mode_q) begin
                step_cnt <= '0;
            end else begin
                case (mode)
                    MODE_AUTO: begin
                        step_cnt <= step_cnt + 1'b1;
                        if (&step_cnt) begin
                            cur_addr <= cur_addr + 1'b1;
                        end
                    end
                    MODE_STEP: begin
                        if (step && !step_q) begin
                            cur_addr <= cur_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Low digits carry the data word, the rest the zero-padded address.
    always_comb begin
        addr_pad = '0;
        addr_pad[ADDR_W-1:0] = cur_addr;
        digit_sh = SH_W'({digit_idx, 2'b00});
        nibble   = '0;
        dp_n     = 1'b1;
        if (digit_sh < DATA_SH) begin
            nibble = 4'(data_q >> digit_sh);
        end else begin
            nibble = 4'(addr_pad >> (digit_sh - DATA_SH));
        end
        if (digit_sh == DATA_SH) begin
            dp_n = 1'b0;
        end
    end

    // an and sseg load on the same edge, so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= '1;
            sseg        <= SSEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt) begin
                an   <= ~(NUM_DIGITS'(1) << digit_idx);
                sseg <= {dp_n, hex_to_sseg(nibble)};
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_scan_display.sv
// Directed bench for mem_scan_display with short refresh/step periods; expected
// display digits and addresses flow through a scoreboard queue.
module tb_mem_scan_display;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 8;
    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_BITS = 2;
    localparam int STEP_BITS    = 3;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  wr_en = 1'b0;
    logic [ADDR_W-1:0]     wr_addr = '0;
    logic [DATA_W-1:0]     wr_data = '0;
    logic [1:0]            mode = 2'b00;
    logic                  step = 1'b0;
    logic [ADDR_W-1:0]     cur_addr;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            sseg;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;

    mem_scan_display #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_BITS (REFRESH_BITS),
        .STEP_BITS    (STEP_BITS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mode     (mode),
        .step     (step),
        .cur_addr (cur_addr),
        .an       (an),
        .sseg     (sseg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic push_display(input logic [7:0] d, input logic [ADDR_W-1:0] a);
        logic [15:0] pad;
        logic [3:0]  nib;
        logic [3:0]  an_exp;
        logic        dp;
        pad = 16'(a);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i < 2) nib = 4'(d >> (4 * i));
            else       nib = 4'(pad >> (4 * (i - 2)));
            dp     = (i == 2) ? 1'b0 : 1'b1;
            an_exp = ~(4'b0001 << i);
            exp_q.push_back(32'({an_exp, dp, seg_of(nib)}));
        end
    endtask

    task automatic wait_an_change(output int cycles);
        logic [NUM_DIGITS-1:0] prev;
        prev   = an;
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (an === prev && cycles < 40);
    endtask

    task automatic check_display(input string tag);
        int cyc;
        int guard;
        guard = 0;
        do begin
            wait_an_change(cyc);
            guard++;
        end while (an !== 4'b1110 && guard < 10);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i > 0) begin
                wait_an_change(cyc);
                check($sformatf("%s_dwell%0d", tag, i), 32'(cyc), 32'd4);
            end
            check($sformatf("%s_digit%0d", tag, i), 32'({an, sseg}), exp_q.pop_front());
        end
    endtask

    task automatic wait_addr_change(output int cycles);
        logic [ADDR_W-1:0] prev;
        prev   = cur_addr;
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (cur_addr === prev && cycles < 20);
    endtask

    initial begin
        int cyc;

        // reset state and first-lit timing
        tick(2);
        check("reset_an", 32'(an), 32'hF);
        check("reset_sseg", 32'(sseg), 32'hFF);
        check("reset_addr", 32'(cur_addr), 32'h0);
        check("reset_data_q", 32'(dut.data_q), 32'h0);
        reset_n = 1'b1;
        tick(3);
        check("first_lit_not_yet", 32'(an), 32'hF);
        tick(1);
        check("first_lit_digit0", 32'(an), 32'hE);

        // hold mode: 3C at address 0
        write_word(10'h000, 8'h3C);
        tick(4);
        check("hold_data_q", 32'(dut.data_q), 32'h3C);
        push_display(8'h3C, 10'h000);
        check_display("disp_3c");

        // auto scan: full lap 0 -> 3FF -> 0, every 8 clocks
        mode = 2'b01;
        exp_addr = '0;
        for (int k = 0; k < (1 << ADDR_W); k++) begin
            exp_addr = exp_addr + 1'b1;
            exp_q.push_back(32'(exp_addr));
            wait_addr_change(cyc);
            check("auto_addr", 32'(cur_addr), exp_q.pop_front());
            check("auto_period", 32'(cyc), (k == 0) ? 32'd9 : 32'd8);
        end
        mode = 2'b00;
        tick(20);
        check("hold_frozen", 32'(cur_addr), 32'h0);

        // manual step: an edge coinciding with the mode change is dropped
        mode = 2'b10;
        step = 1'b1;
        tick(5);
        check("step_in_mode_change", 32'(cur_addr), 32'h0);
        step = 1'b0;
        tick(5);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick(5);
            step = 1'b0;
            tick(5);
        end
        exp_addr = 10'h003;
        check("step_three_pulses", 32'(cur_addr), 32'(exp_addr));
        mode = 2'b00;
        tick(2);

        // write to the displayed address: visible two edges later
        write_word(exp_addr, 8'h11);
        tick(3);
        check("pre_write_data_q", 32'(dut.data_q), 32'h11);
        write_word(exp_addr, 8'hA5);
        tick(1);
        check("write_edge1_old", 32'(dut.data_q), 32'h11);
        tick(1);
        check("write_edge2_new", 32'(dut.data_q), 32'hA5);
        push_display(8'hA5, exp_addr);
        check_display("disp_a5");

        // asynchronous reset mid-run
        check("pre_reset_an_lit", 32'(an !== 4'hF), 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'hF);
        check("async_reset_sseg", 32'(sseg), 32'hFF);
        check("async_reset_addr", 32'(cur_addr), 32'h0);
        check("async_reset_data_q", 32'(dut.data_q), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("post_reset_dark", 32'(an), 32'hF);
        tick(2);
        check("post_reset_digit0", 32'(an), 32'hE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
